fpa_issue_ctrl: RTL

Flow-control stage directly upstream of the 36-cycle pipelined floating-point adder. It accepts IEEE-754 single-precision operand pairs on a valid/ready interface and drives them onto the adder's A/B inputs. Because the adder has no valid, stall, or reset, this block carries a valid+tag shadow pipeline matched to the adder latency. It captures each SUM into a result FIFO and uses credits to guarantee that FIFO never overflows.

---
 rtl/fpa_pkg.sv | 16 +
 rtl/fpa_result_fifo.sv | 56 +++++
 rtl/fpa_issue_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/fpa_pkg.sv
// Shared constants and types for the floating-point adder issue controller.
// The shadow entry mirrors one adder pipeline slot: does it hold a live op, and whose.
package fpa_pkg;

  localparam int FPA_LATENCY = 36;
  localparam int FPA_TAG_W   = 4;
  localparam int FPA_DEPTH   = 8;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic                 valid;
    logic [FPA_TAG_W-1:0] tag;
  } shadow_t;

endpackage

// File: rtl/fpa_result_fifo.sv
// Synchronous result FIFO with occupancy count; the head entry is presented combinationally.
// Storage is not reset, only the pointers and the count.
module fpa_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Upstream credits make both of these unreachable; they guard the credit arithmetic.
  assert property (@(posedge clk) disable iff (reset) !(push && full))
    else $error("fpa_result_fifo: push while full");
  assert property (@(posedge clk) disable iff (reset) !(pop && empty))
    else $error("fpa_result_fifo: pop while empty");

endmodule

// File: rtl/fpa_issue_ctrl.sv
// Issue/return control around a fixed-latency pipelined FP adder that has no valid or stall.
// A shadow shift register tracks live ops; credits keep the result FIFO from ever overflowing.
module fpa_issue_ctrl
  import fpa_pkg::*;
#(
  parameter int LATENCY = FPA_LATENCY,
  parameter int TAG_W   = FPA_TAG_W,
  parameter int DEPTH   = FPA_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              fpa_a,
  output logic [31:0]              fpa_b,
  input  logic [31:0]              fpa_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_sum,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   inflight
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int FIFO_W = 32 + TAG_W;

  if (TAG_W != FPA_TAG_W) begin : g_tag_w_check
    $error("fpa_issue_ctrl: TAG_W must equal fpa_pkg::FPA_TAG_W");
  end

  // Stage 0 is loaded alongside fpa_a/fpa_b; stages 1..LATENCY track the adder's registers.
  shadow_t shadow_q [LATENCY+1];

  logic              accept;
  logic              capture;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credits_used;
  logic [FIFO_W-1:0] fifo_head;

  assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_ready     = !fifo_full && (credits_used < (CNT_W+1)'(DEPTH));
  assign accept       = in_valid && in_ready;
  assign capture      = shadow_q[LATENCY].valid;
  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fpa_a    <= FP_ZERO;
      fpa_b    <= FP_ZERO;
      inflight <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      // Idle slots feed 0+0 so the adder never chews on stale operands.
      fpa_a             <= accept ? in_a : FP_ZERO;
      fpa_b             <= accept ? in_b : FP_ZERO;
      shadow_q[0].valid <= accept;
      shadow_q[0].tag   <= in_tag;
      for (int i = 1; i <= LATENCY; i++) begin
        shadow_q[i] <= shadow_q[i-1];
      end
      inflight <= inflight + CNT_W'(accept) - CNT_W'(capture);
    end
  end

  fpa_result_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data ({fpa_sum, shadow_q[LATENCY].tag}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {out_sum, out_tag} = fifo_head;

endmodule
